data_mem_arbiter: RTL and testbench

//  Shares the single byte-addressed 64-bit data memory between two requesters:

---
 rtl/data_mem_arbiter_if.sv | 23 ++
 rtl/data_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_data_mem_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_if.sv
// One requester's request/response channel into the data memory arbiter.
// The requester drives the master side and the arbiter implements the slave side.
interface data_mem_arbiter_if;
  logic        valid;
  logic        ready;
  logic        write;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output valid, write, addr, wdata, rsp_ready,
    input  ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  valid, write, addr, wdata, rsp_ready,
    output ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a byte-addressed 64-bit data memory.
// It allows one doubleword access in flight at a time: IDLE -> ACCESS -> RESP.
module data_mem_arbiter #(
  parameter int unsigned MemBytes = 64,
  parameter int unsigned PrioMode = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  data_mem_arbiter_if.slave r0_io,
  data_mem_arbiter_if.slave r1_io,
  output logic [63:0]       mem_addr_o,
  output logic [63:0]       mem_wdata_o,
  output logic              mem_write_o,
  output logic              mem_read_o,
  input  logic [63:0]       mem_rdata_i
);

  localparam logic [63:0] MaxAddr = 64'(MemBytes) - 64'd8;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e      state_q, state_d;
  logic        rr_q, rr_d;  // port favoured when both request
  logic        id_q, id_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        mem_write_q, mem_write_d;
  logic        mem_read_q, mem_read_d;
  logic [63:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        winner;
  logic        accept;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        req_err;
  logic        rsp_hs;
  logic        rsp_valid0;
  logic        rsp_valid1;

  function automatic logic addr_err(input logic [63:0] a);
    return (a[2:0] != 3'b000) || (a > MaxAddr);
  endfunction

  always_comb begin
    if (r0_io.valid && !r1_io.valid) begin
      winner = 1'b0;
    end else if (r1_io.valid && !r0_io.valid) begin
      winner = 1'b1;
    end else if (PrioMode != 0) begin
      winner = 1'b0;
    end else begin
      winner = rr_q;
    end
  end

  // Ready is withheld while reset is asserted so every output reads 0 in reset.
  assign accept      = (state_q == StIdle) && !rst_i && (r0_io.valid || r1_io.valid);
  assign r0_io.ready = accept && !winner;
  assign r1_io.ready = accept && winner;

  assign req_write = winner ? r1_io.write : r0_io.write;
  assign req_addr  = winner ? r1_io.addr  : r0_io.addr;
  assign req_wdata = winner ? r1_io.wdata : r0_io.wdata;
  assign req_err   = addr_err(req_addr);

  assign rsp_hs = (state_q == StResp) && (id_q ? r1_io.rsp_ready : r0_io.rsp_ready);

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    id_d        = id_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_write_d = 1'b0;
    mem_read_d  = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d     = StAccess;
          id_d        = winner;
          rr_d        = ~winner;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          // Strobes are registered, so legality is decided as the request is latched.
          mem_write_d = req_write && !req_err;
          mem_read_d  = !req_write && !req_err;
        end
      end
      StAccess: begin
        state_d     = StResp;
        rsp_err_d   = addr_err(addr_q);
        rsp_rdata_d = mem_read_q ? mem_rdata_i : 64'd0;
      end
      StResp: begin
        if (rsp_hs) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      rr_q        <= 1'b0;
      id_q        <= 1'b0;
      addr_q      <= 64'd0;
      wdata_q     <= 64'd0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      rsp_rdata_q <= 64'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_write_q <= mem_write_d;
      mem_read_q  <= mem_read_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_write_o = mem_write_q;
  assign mem_read_o  = mem_read_q;

  assign rsp_valid0 = (state_q == StResp) && !id_q;
  assign rsp_valid1 = (state_q == StResp) && id_q;

  assign r0_io.rsp_valid = rsp_valid0;
  assign r0_io.rsp_rdata = rsp_valid0 ? rsp_rdata_q : 64'd0;
  assign r0_io.rsp_err   = rsp_valid0 && rsp_err_q;
  assign r1_io.rsp_valid = rsp_valid1;
  assign r1_io.rsp_rdata = rsp_valid1 ? rsp_rdata_q : 64'd0;
  assign r1_io.rsp_err   = rsp_valid1 && rsp_err_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter share one stimulus,
// and each arbiter drives its own 64-byte memory model.
module tb_data_mem_arbiter;

  localparam logic [63:0] T1Data = 64'h1122_3344_5566_7788;
  localparam logic [63:0] MemInit [8] = '{
    64'hC0DE_0000_0000_0000, 64'hC0DE_0000_0000_0001, 64'hC0DE_0000_0000_0002,
    64'hC0DE_0000_0000_0003, 64'hC0DE_0000_0000_0004, 64'hC0DE_0000_0000_0005,
    64'hC0DE_0000_0000_0006, 64'hC0DE_0000_0000_0007
  };

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  valid, write, rsp_ready;
  logic [63:0] addr [2];
  logic [63:0] wdata [2];

  always #5 clk = ~clk;

  data_mem_arbiter_if rr0 ();
  data_mem_arbiter_if rr1 ();
  data_mem_arbiter_if fp0 ();
  data_mem_arbiter_if fp1 ();

  assign rr0.valid = valid[0]; assign rr0.write = write[0]; assign rr0.addr = addr[0];
  assign rr0.wdata = wdata[0]; assign rr0.rsp_ready = rsp_ready[0];
  assign rr1.valid = valid[1]; assign rr1.write = write[1]; assign rr1.addr = addr[1];
  assign rr1.wdata = wdata[1]; assign rr1.rsp_ready = rsp_ready[1];
  assign fp0.valid = valid[0]; assign fp0.write = write[0]; assign fp0.addr = addr[0];
  assign fp0.wdata = wdata[0]; assign fp0.rsp_ready = rsp_ready[0];
  assign fp1.valid = valid[1]; assign fp1.write = write[1]; assign fp1.addr = addr[1];
  assign fp1.wdata = wdata[1]; assign fp1.rsp_ready = rsp_ready[1];

  logic [63:0] rr_maddr, rr_mwdata, rr_mrdata, fp_maddr, fp_mwdata, fp_mrdata;
  logic        rr_mwrite, rr_mread, fp_mwrite, fp_mread;
  logic [63:0] mem_rr [8] = MemInit;
  logic [63:0] mem_fp [8] = MemInit;

  data_mem_arbiter #(.MemBytes(64), .PrioMode(0)) u_rr (
    .clk_i       (clk),
    .rst_i       (rst),
    .r0_io       (rr0),
    .r1_io       (rr1),
    .mem_addr_o  (rr_maddr),
    .mem_wdata_o (rr_mwdata),
    .mem_write_o (rr_mwrite),
    .mem_read_o  (rr_mread),
    .mem_rdata_i (rr_mrdata)
  );

  data_mem_arbiter #(.MemBytes(64), .PrioMode(1)) u_fp (
    .clk_i       (clk),
    .rst_i       (rst),
    .r0_io       (fp0),
    .r1_io       (fp1),
    .mem_addr_o  (fp_maddr),
    .mem_wdata_o (fp_mwdata),
    .mem_write_o (fp_mwrite),
    .mem_read_o  (fp_mread),
    .mem_rdata_i (fp_mrdata)
  );

  assign rr_mrdata = mem_rr[rr_maddr[5:3]];
  assign fp_mrdata = mem_fp[fp_maddr[5:3]];
  always @(posedge clk) if (rr_mwrite) mem_rr[rr_maddr[5:3]] <= rr_mwdata;
  always @(posedge clk) if (fp_mwrite) mem_fp[fp_maddr[5:3]] <= fp_mwdata;

  wire [1:0] rr_ready = {rr1.ready, rr0.ready};
  wire [1:0] rr_rspv  = {rr1.rsp_valid, rr0.rsp_valid};
  wire [1:0] fp_ready = {fp1.ready, fp0.ready};
  wire [1:0] fp_rspv  = {fp1.rsp_valid, fp0.rsp_valid};

  int wr_cnt = 0;
  int rd_cnt = 0;
  always @(negedge clk) begin
    if (rr_mwrite) wr_cnt++;
    if (rr_mread) rd_cnt++;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 64'({rr_ready, fp_ready}), 64'd0);
    check_eq({tag, "_rspv"}, 64'({rr_rspv, fp_rspv}), 64'd0);
    check_eq({tag, "_err"}, 64'({rr0.rsp_err, rr1.rsp_err}), 64'd0);
    check_eq({tag, "_strobes"}, 64'({rr_mwrite, rr_mread, fp_mwrite, fp_mread}), 64'd0);
    check_eq({tag, "_maddr"}, rr_maddr, 64'd0);
    check_eq({tag, "_mwdata"}, rr_mwdata, 64'd0);
    check_eq({tag, "_rdata"}, rr0.rsp_rdata | rr1.rsp_rdata, 64'd0);
  endtask

  // Single-port transaction on the round-robin arbiter with rsp_ready high.
  task automatic do_txn(input int p, input logic wr, input logic [63:0] a, input logic [63:0] d,
                        input logic [63:0] exp_rd, input logic exp_err, input string tag);
    int n;
    valid[p] = 1'b1; write[p] = wr; addr[p] = a; wdata[p] = d;
    n = 0;
    @(negedge clk);
    while (!rr_ready[p] && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_ready"}, 64'(rr_ready[p]), 64'd1);
    @(posedge clk);
    #1;
    valid[p] = 1'b0;
    @(negedge clk);
    check_eq({tag, "_acc_strobes"}, 64'({rr_mwrite, rr_mread}),
             64'({wr & ~exp_err, ~wr & ~exp_err}));
    check_eq({tag, "_acc_maddr"}, rr_maddr, a);
    check_eq({tag, "_acc_rspv"}, 64'(rr_rspv), 64'd0);
    @(negedge clk);
    check_eq({tag, "_rspv"}, 64'(rr_rspv), 64'(2'b01 << p));
    check_eq({tag, "_rdata"}, p ? rr1.rsp_rdata : rr0.rsp_rdata, exp_rd);
    check_eq({tag, "_err"}, 64'(p ? rr1.rsp_err : rr0.rsp_err), 64'(exp_err));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;
    rst = 1'b1;
    valid = 2'b11; write = 2'b00; rsp_ready = 2'b11;
    addr[0] = 64'd0; addr[1] = 64'd0; wdata[0] = 64'd0; wdata[1] = 64'd0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    valid = 2'b00;
    rst = 1'b0;

    // T1: store then load at addr 8
    do_txn(0, 1'b1, 64'd8, T1Data, 64'd0, 1'b0, "t1_store");
    check_eq("t1_mem1", mem_rr[1], T1Data);
    do_txn(0, 1'b0, 64'd8, 64'd0, T1Data, 1'b0, "t1_load");

    // T4: illegal accesses leave memory alone; addr 56 is the last legal doubleword
    g = wr_cnt + rd_cnt;
    do_txn(1, 1'b0, 64'd3, 64'd0, 64'd0, 1'b1, "t4_load_3");
    do_txn(0, 1'b1, 64'd60, 64'hDEAD_BEEF_DEAD_BEEF, 64'd0, 1'b1, "t4_store_60");
    do_txn(0, 1'b0, 64'd64, 64'd0, 64'd0, 1'b1, "t4_load_64");
    check_eq("t4_no_strobes", 64'(wr_cnt + rd_cnt - g), 64'd0);
    check_eq("t4_mem7", mem_rr[7], MemInit[7]);
    check_eq("t4_mem0", mem_rr[0], MemInit[0]);
    do_txn(1, 1'b1, 64'd56, 64'h0F0E_0D0C_0B0A_0908, 64'd0, 1'b0, "t4_store_56");
    do_txn(1, 1'b0, 64'd56, 64'd0, 64'h0F0E_0D0C_0B0A_0908, 1'b0, "t4_load_56");

    // T5: response back-pressure on port 1 while port 0 waits
    rsp_ready = 2'b01;
    valid[1] = 1'b1; write[1] = 1'b0; addr[1] = 64'd8;
    @(negedge clk);
    check_eq("t5_ready", 64'(rr_ready), 64'd2);
    @(posedge clk);
    #1;
    valid[1] = 1'b0;
    valid[0] = 1'b1; write[0] = 1'b0; addr[0] = 64'd0;
    @(negedge clk);
    check_eq("t5_acc_ready", 64'(rr_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t5_hold_rspv", 64'(rr_rspv), 64'd2);
      check_eq("t5_hold_rdata", rr1.rsp_rdata, T1Data);
      check_eq("t5_hold_ready", 64'(rr_ready), 64'd0);
    end
    rsp_ready = 2'b11;
    @(negedge clk);
    check_eq("t5_idle_rspv", 64'(rr_rspv), 64'd0);
    check_eq("t5_idle_ready", 64'(rr_ready), 64'd1);
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("t5_p0_rspv", 64'(rr_rspv), 64'd1);
    check_eq("t5_p0_rdata", rr0.rsp_rdata, MemInit[0]);
    @(posedge clk);
    #1;

    // T6: reset during the ACCESS cycle of a store
    valid[0] = 1'b1; write[0] = 1'b1; addr[0] = 64'd16; wdata[0] = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    check_eq("t6_ready", 64'(rr_ready), 64'd1);
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    @(negedge clk);
    check_eq("t6_acc_write", 64'(rr_mwrite), 64'd1);
    rst = 1'b1;
    valid[1] = 1'b1;
    #1;
    check_eq("t6_write_drop", 64'(rr_mwrite), 64'd0);
    check_reset_outputs("t6_rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    valid[1] = 1'b0;
    check_eq("t6_mem2", mem_rr[2], MemInit[2]);
    do_txn(0, 1'b0, 64'd16, 64'd0, MemInit[2], 1'b0, "t6_load");

    // T2/T3: both ports always valid; round-robin alternates, fixed priority keeps port 0
    rst = 1'b1;
    @(posedge clk);
    #1;
    valid = 2'b11; write = 2'b00; addr[0] = 64'd0; addr[1] = 64'd8; rsp_ready = 2'b11;
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      g = (k / 3) % 2;
      check_eq("t2_rr_ready", 64'(rr_ready), (k % 3 == 0) ? 64'(2'b01 << g) : 64'd0);
      check_eq("t3_fp_ready", 64'(fp_ready), (k % 3 == 0) ? 64'd1 : 64'd0);
      check_eq("t2_rr_rspv", 64'(rr_rspv), (k % 3 == 2) ? 64'(2'b01 << g) : 64'd0);
      check_eq("t3_fp_rspv", 64'(fp_rspv), (k % 3 == 2) ? 64'd1 : 64'd0);
      if (k % 3 == 2) begin
        check_eq("t2_rr_rdata", g ? rr1.rsp_rdata : rr0.rsp_rdata, g ? T1Data : MemInit[0]);
        check_eq("t3_fp_rdata", fp0.rsp_rdata, MemInit[0]);
      end
    end
    valid = 2'b00;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
